// File: rtl/mmio_axil_initiator.sv
// MMIO command to AXI-lite initiator with one transaction outstanding.
// Define MMIO_AXIL_INITIATOR_TIMEOUT_EN to bound the wait for AXI responses.
module mmio_axil_initiator #(
  parameter int ADDR_W         = 16,
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [63:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [63:0]       rsp_data,
  output logic              rsp_error,
  output logic              rsp_timeout,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [ID_W-1:0]   awid,
  output logic              wvalid,
  input  logic              wready,
  output logic [63:0]       wdata,
  output logic [7:0]        wstrb,
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  input  logic [ID_W-1:0]   bid,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  input  logic              rvalid,
  output logic              rready,
  input  logic [63:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic [ID_W-1:0]   rid
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   tag_q, tag_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdat_q, wdat_d;
  logic              awdn_q, awdn_d;
  logic              wdn_q, wdn_d;
  logic [63:0]       data_q, data_d;
  logic              err_q, err_d;

`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tflag_q, tflag_d;
  logic          busy;
  assign busy = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                (state_q == RD_REQ) || (state_q == RD_RESP);
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      id_q    <= '0;
      tag_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdat_q  <= '0;
      awdn_q  <= 1'b0;
      wdn_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
      tmo_q   <= '0;
      tflag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      awdn_q  <= awdn_d;
      wdn_q   <= wdn_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
      tmo_q   <= tmo_d;
      tflag_q <= tflag_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    tag_d   = tag_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    awdn_d  = awdn_q;
    wdn_d   = wdn_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          wr_d    = cmd_write;
          addr_d  = cmd_addr;
          wdat_d  = cmd_wdata;
          tag_d   = id_q;
          id_d    = id_q + ID_W'(1);
          awdn_d  = 1'b0;
          wdn_d   = 1'b0;
          state_d = cmd_write ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // each channel retires on its own handshake
        awdn_d = awdn_q | awready;
        wdn_d  = wdn_q | wready;
        if (awdn_d && wdn_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) begin
          data_d  = '0;
          err_d   = (bresp != 2'b00) | (bid != tag_q);
          state_d = RSP;
        end
      end
      RD_REQ: begin
        if (arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (rvalid) begin
          data_d  = rdata;
          err_d   = (rresp != 2'b00) | (rid != tag_q);
          state_d = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
    tmo_d   = busy ? tmo_q + TW'(1) : '0;
    tflag_d = (state_q == IDLE) ? 1'b0 : tflag_q;
    if (busy && tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = RSP;
      data_d  = '0;
      err_d   = 1'b1;
      tflag_d = 1'b1;
    end
`endif
  end

  always_comb begin
    cmd_ready = reset_n && (state_q == IDLE);
    awvalid   = (state_q == WR_REQ) && !awdn_q;
    wvalid    = (state_q == WR_REQ) && !wdn_q;
    awaddr    = addr_q & ~ADDR_W'(7);
    awid      = tag_q;
    wdata     = wdat_q;
    wstrb     = 8'hFF;
    bready    = (state_q == WR_RESP);
    arvalid   = (state_q == RD_REQ);
    araddr    = addr_q & ~ADDR_W'(7);
    arid      = tag_q;
    rready    = (state_q == RD_RESP);
    rsp_valid = (state_q == RSP);
    rsp_write = wr_q;
    rsp_data  = data_q;
    rsp_error = err_q;
`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
    rsp_timeout = tflag_q;
`else
    rsp_timeout = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mmio_axil_initiator.sv
// Randomized self-checking bench for mmio_axil_initiator with a scripted
// AXI-lite slave and a transaction-level expectation model.
`timescale 1ns/1ps
module tb_mmio_axil_initiator;
  localparam int AW = 16;
  localparam int IW = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [63:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_write, rsp_error, rsp_timeout;
  logic [63:0] rsp_data;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [IW-1:0] awid, arid, bid, rid;
  logic [63:0] wdata, rdata;
  logic [7:0] wstrb;
  logic [1:0] bresp, rresp;

  always #5 clk = ~clk;

  mmio_axil_initiator #(
    .ADDR_W(AW), .ID_W(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_write(rsp_write), .rsp_data(rsp_data),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .awvalid(awvalid), .awready(awready),
    .awaddr(awaddr), .awid(awid),
    .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready),
    .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready),
    .araddr(araddr), .arid(arid),
    .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .rresp(rresp), .rid(rid)
  );

  typedef struct {
    logic [15:0] addr;
    logic [3:0]  id;
    logic [7:0]  strb;
    logic [63:0] wd;
    int          nb;
    int          nr;
    logic        rw;
    logic [63:0] data;
    logic        err;
    logic        tmo;
    bit          ok;
    int          c_req;
    int          c_rdy;
    int          c_rsp;
    bit          unstable;
    int          bad_rdy;
    bit          cmd_rdy_in_rsp;
    logic        post_cmd_rdy;
    logic        post_rsp_v;
  } txn_t;

  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] id_m;

  task automatic clear_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 0; awready = 0; wready = 0; arready = 0;
    bvalid = 0; bresp = 0; bid = 0;
    rvalid = 0; rresp = 0; rid = 0; rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    id_m = 0;
  endtask

  // One command through a scripted slave; returns what was observed.
  task automatic axi_txn(
    input bit wr, input logic [15:0] a, input logic [63:0] wd,
    input int aw_d, input int w_d, input int r_d,
    input logic [1:0] resp, input logic [3:0] idx,
    input logic [63:0] rd, input int hold, input bit stray,
    output txn_t o);
    bit aw_ok, w_ok, ar_ok, sent, done, seen, ad;
    int wc, hc;
    logic [63:0] d0;
    logic [2:0] f0;
    o = '{default: 0};
    o.c_req = -1; o.c_rdy = -1; o.c_rsp = -1;
    aw_ok = 0; w_ok = 0; ar_ok = 0; sent = 0;
    done = 0; seen = 0; wc = 0; hc = 0;
    d0 = '0; f0 = '0;
    for (int k = 0; k < 50 && !cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    if (!cmd_ready) return;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    @(posedge clk); #1;
    cmd_valid = 0; cmd_write = 1'($urandom);
    cmd_addr = 16'($urandom); cmd_wdata = {$urandom, $urandom};
    for (int c = 0; c < 200 && !done; c++) begin
      ad = wr ? (aw_ok && w_ok) : ar_ok;
      awready = wr && c >= aw_d;
      wready  = wr && c >= w_d;
      arready = !wr && c >= aw_d;
      bvalid = 0; rvalid = 0; bresp = 2'b11; rresp = 2'b11;
      bid = ~o.id; rid = ~o.id; rdata = '1;
      if (ad && !sent) begin
        if (wc >= r_d) begin
          bvalid = wr; rvalid = !wr;
          bresp = resp; rresp = resp;
          bid = o.id ^ idx; rid = o.id ^ idx; rdata = rd;
        end
        wc++;
      end else if (!ad && stray) begin
        bvalid = 1; rvalid = 1;
      end
      if (awvalid) begin o.addr = awaddr; o.id = awid; end
      if (arvalid) begin o.addr = araddr; o.id = arid; end
      if (wvalid) begin o.strb = wstrb; o.wd = wdata; end
      if ((awvalid || arvalid) && o.c_req < 0) o.c_req = c;
      if ((bready || rready) && o.c_rdy < 0) o.c_rdy = c;
      if ((bready && !wr) || (rready && wr) ||
          ((bready || rready) && !ad)) o.bad_rdy++;
      if (bvalid && bready) begin o.nb++; sent = 1; end
      if (rvalid && rready) begin o.nr++; sent = 1; end
      if (awvalid && awready) aw_ok = 1;
      if (wvalid && wready) w_ok = 1;
      if (arvalid && arready) ar_ok = 1;
      rsp_ready = 0;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; o.c_rsp = c;
          o.rw = rsp_write; o.data = rsp_data;
          o.err = rsp_error; o.tmo = rsp_timeout;
          d0 = rsp_data; f0 = {rsp_write, rsp_error, rsp_timeout};
        end else if (rsp_data !== d0 ||
                     {rsp_write, rsp_error, rsp_timeout} !== f0) begin
          o.unstable = 1;
        end
        if (cmd_ready) o.cmd_rdy_in_rsp = 1;
        if (awvalid || wvalid || arvalid || bready || rready)
          o.bad_rdy++;
        rsp_ready = (hc >= hold);
        if (rsp_ready) done = 1;
        hc++;
      end
      @(posedge clk); #1;
    end
    o.ok = done;
    o.post_cmd_rdy = cmd_ready;
    o.post_rsp_v = rsp_valid;
    awready = 0; wready = 0; arready = 0;
    bvalid = 0; rvalid = 0; rsp_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready);
    end
    n_chk++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 000000",
        {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    n_chk++;
    if ({rsp_error, rsp_timeout, rsp_data} !== 66'b0) begin
      n_fail++;
      $display("FAIL reset_rsp: got err=%b tmo=%b data=%h expected 0 0 0",
        rsp_error, rsp_timeout, rsp_data);
    end
    reset_n = 1; id_m = 0;
    #1;
    n_chk++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_read_basic();
    txn_t o;
    axi_txn(0, 16'h0008, 64'h0, 0, 0, 0, 2'b00, 4'h0,
      64'h0123456789ABCDEF, 0, 0, o);
    n_chk++;
    if (!o.ok || o.addr !== 16'h0008 || o.id !== 4'h0) begin
      n_fail++;
      $display("FAIL rd_basic_req: got ok=%0d araddr=%h arid=%h expected 1 0008 0",
        o.ok, o.addr, o.id);
    end
    n_chk++;
    if (o.data !== 64'h0123456789ABCDEF || o.err !== 1'b0 || o.rw !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_basic_rsp: got data=%h err=%b wr=%b expected 0123456789abcdef 0 0",
        o.data, o.err, o.rw);
    end
    n_chk++;
    if (o.c_req != 0 || o.c_rdy != 1 || o.c_rsp != 2) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d/%0d/%0d expected 0/1/2",
        o.c_req, o.c_rdy, o.c_rsp);
    end
    n_chk++;
    if (o.post_cmd_rdy !== 1'b1 || o.post_rsp_v !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_return_idle: got ready=%b rsp_valid=%b expected 1 0",
        o.post_cmd_rdy, o.post_rsp_v);
    end
    id_m++;
  endtask

  task automatic test_write_slow_aw();
    txn_t o;
    axi_txn(1, 16'h0045, 64'hDEADBEEF, 3, 0, 0, 2'b00, 4'h0,
      64'h0, 0, 0, o);
    n_chk++;
    if (o.addr !== 16'h0040 || o.strb !== 8'hFF ||
        o.wd !== 64'hDEADBEEF || o.id !== id_m) begin
      n_fail++;
      $display("FAIL wr_slow_req: got addr=%h strb=%h wd=%h id=%h expected 0040 ff deadbeef %h",
        o.addr, o.strb, o.wd, o.id, id_m);
    end
    n_chk++;
    if (!o.ok || o.nb != 1 || o.rw !== 1'b1 ||
        o.err !== 1'b0 || o.data !== 64'h0) begin
      n_fail++;
      $display("FAIL wr_slow_rsp: got ok=%0d nb=%0d wr=%b err=%b data=%h expected 1 1 1 0 0",
        o.ok, o.nb, o.rw, o.err, o.data);
    end
    n_chk++;
    if (o.c_rdy != 4 || o.c_rsp != 5 || o.bad_rdy != 0) begin
      n_fail++;
      $display("FAIL wr_slow_timing: got rdy=%0d rsp=%0d bad=%0d expected 4 5 0",
        o.c_rdy, o.c_rsp, o.bad_rdy);
    end
    id_m++;
    axi_txn(1, 16'h1237, 64'h55, 0, 0, 0, 2'b00, 4'h0,
      64'h0, 0, 0, o);
    n_chk++;
    if (o.c_req != 0 || o.c_rdy != 1 || o.c_rsp != 2 || o.id !== id_m) begin
      n_fail++;
      $display("FAIL wr_latency: got %0d/%0d/%0d id=%h expected 0/1/2 id=%h",
        o.c_req, o.c_rdy, o.c_rsp, o.id, id_m);
    end
    id_m++;
  endtask

  task automatic test_errors();
    txn_t o;
    axi_txn(0, 16'h0100, 64'h0, 0, 0, 1, 2'b10, 4'h0,
      64'h1111, 0, 0, o);
    n_chk++;
    if (!o.ok || o.err !== 1'b1 || o.tmo !== 1'b0 || o.id !== id_m) begin
      n_fail++;
      $display("FAIL err_rresp: got ok=%0d err=%b tmo=%b id=%h expected 1 1 0 %h",
        o.ok, o.err, o.tmo, o.id, id_m);
    end
    id_m++;
    axi_txn(1, 16'h0200, 64'h2222, 1, 2, 0, 2'b00, 4'h1,
      64'h0, 0, 0, o);
    n_chk++;
    if (!o.ok || o.err !== 1'b1 || o.tmo !== 1'b0 || o.nb != 1) begin
      n_fail++;
      $display("FAIL err_bid: got ok=%0d err=%b tmo=%b nb=%0d expected 1 1 0 1",
        o.ok, o.err, o.tmo, o.nb);
    end
    id_m++;
  endtask

  task automatic test_rsp_hold();
    txn_t o;
    logic [63:0] d;
    d = {$urandom, $urandom};
    axi_txn(0, 16'h0330, 64'h0, 0, 0, 0, 2'b00, 4'h0, d, 3, 0, o);
    n_chk++;
    if (o.unstable || o.cmd_rdy_in_rsp || o.data !== d) begin
      n_fail++;
      $display("FAIL rsp_hold: got unstable=%0d cmd_ready=%0d data=%h expected 0 0 %h",
        o.unstable, o.cmd_rdy_in_rsp, o.data, d);
    end
    n_chk++;
    if (o.post_cmd_rdy !== 1'b1 || o.post_rsp_v !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_hold_release: got ready=%b rsp_valid=%b expected 1 0",
        o.post_cmd_rdy, o.post_rsp_v);
    end
    id_m++;
  endtask

  task automatic test_stray();
    txn_t o;
    logic [63:0] d;
    axi_txn(1, 16'h0410, 64'h77, 2, 1, 1, 2'b00, 4'h0, 64'h0, 0, 1, o);
    n_chk++;
    if (o.err !== 1'b0 || o.nb != 1 || o.bad_rdy != 0 || o.id !== id_m) begin
      n_fail++;
      $display("FAIL stray_wr: got err=%b nb=%0d bad=%0d id=%h expected 0 1 0 %h",
        o.err, o.nb, o.bad_rdy, o.id, id_m);
    end
    id_m++;
    d = {$urandom, $urandom};
    axi_txn(0, 16'h0418, 64'h0, 2, 0, 1, 2'b00, 4'h0, d, 0, 1, o);
    n_chk++;
    if (o.err !== 1'b0 || o.nr != 1 || o.bad_rdy != 0 || o.data !== d) begin
      n_fail++;
      $display("FAIL stray_rd: got err=%b nr=%0d bad=%0d data=%h expected 0 1 0 %h",
        o.err, o.nr, o.bad_rdy, o.data, d);
    end
    id_m++;
  endtask

  task automatic test_random();
    txn_t o;
    bit wr;
    logic [15:0] a;
    logic [63:0] wd, rd, ed;
    logic [1:0] rs;
    logic [3:0] ix;
    logic ee;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom);
      a = 16'($urandom);
      wd = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      rs = ($urandom_range(3, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      ix = ($urandom_range(4, 0) == 0) ? 4'($urandom_range(15, 1)) : 4'h0;
      axi_txn(wr, a, wd, $urandom_range(3, 0), $urandom_range(3, 0),
        $urandom_range(4, 0), rs, ix, rd, $urandom_range(2, 0),
        1'($urandom), o);
      ee = (rs != 2'b00) || (ix != 4'h0);
      ed = wr ? 64'h0 : rd;
      n_chk++;
      if (!o.ok || o.addr !== (a & 16'hFFF8) || o.id !== id_m ||
          o.rw !== wr || o.err !== ee || o.tmo !== 1'b0 ||
          o.data !== ed || o.bad_rdy != 0 || o.unstable ||
          (wr && (o.strb !== 8'hFF || o.wd !== wd || o.nb != 1)) ||
          (!wr && o.nr != 1)) begin
        n_fail++;
        $display("FAIL random_%0d: got ok=%0d addr=%h id=%h wr=%b err=%b data=%h bad=%0d expected addr=%h id=%h wr=%b err=%b data=%h",
          i, o.ok, o.addr, o.id, o.rw, o.err, o.data, o.bad_rdy,
          a & 16'hFFF8, id_m, wr, ee, ed);
      end
      id_m++;
    end
  endtask

  task automatic test_back_to_back();
    txn_t o;
    logic [63:0] d;
    do_reset();
    for (int k = 0; k < 17; k++) begin
      d = {$urandom, $urandom};
      axi_txn(0, 16'(k * 8), 64'h0, 0, 0, 0, 2'b00, 4'h0, d, 0, 0, o);
      n_chk++;
      if (!o.ok || o.id !== 4'(k) || o.err !== 1'b0 || o.data !== d) begin
        n_fail++;
        $display("FAIL b2b_%0d: got ok=%0d id=%h err=%b data=%h expected 1 %h 0 %h",
          k, o.ok, o.id, o.err, o.data, 4'(k), d);
      end
      id_m++;
    end
  endtask

  task automatic test_reset_mid();
    txn_t o;
    bit got;
    rsp_ready = 0;
    cmd_valid = 1; cmd_write = 1; cmd_addr = 16'h0500; cmd_wdata = 64'h9;
    @(posedge clk); #1;
    cmd_valid = 0; awready = 1; wready = 1;
    @(posedge clk); #1;
    awready = 0; wready = 0;
    n_chk++;
    if (bready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wr_resp: got bready=%b expected 1", bready);
    end
    reset_n = 0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_cmd_ready: got %b expected 0", cmd_ready);
    end
    reset_n = 1; id_m = 0;
    n_chk++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_fail++;
      $display("FAIL mid_valids: got %b expected 000000",
        {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    got = 0;
    bvalid = 1; bid = 0; bresp = 0;
    for (int k = 0; k < 5; k++) begin
      if (rsp_valid) got = 1;
      @(posedge clk); #1;
    end
    bvalid = 0;
    n_chk++;
    if (got) begin
      n_fail++;
      $display("FAIL mid_no_rsp: got rsp_valid=1 expected 0");
    end
    axi_txn(1, 16'h0508, 64'h1, 0, 0, 0, 2'b00, 4'h0, 64'h0, 0, 0, o);
    n_chk++;
    if (!o.ok || o.id !== 4'h0 || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_next_id: got ok=%0d awid=%h err=%b expected 1 0 0",
        o.ok, o.id, o.err);
    end
    id_m++;
  endtask

  task automatic test_timeout();
    txn_t o;
    axi_txn(0, 16'h0600, 64'h0, 0, 0, 100000, 2'b00, 4'h0,
      64'hFFFF, 0, 0, o);
`ifdef MMIO_AXIL_INITIATOR_TIMEOUT_EN
    n_chk++;
    if (!o.ok || o.err !== 1'b1 || o.tmo !== 1'b1 || o.data !== 64'h0) begin
      n_fail++;
      $display("FAIL tmo_rsp: got ok=%0d err=%b tmo=%b data=%h expected 1 1 1 0",
        o.ok, o.err, o.tmo, o.data);
    end
    n_chk++;
    if (o.c_rsp != TO || o.bad_rdy != 0 || rready !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_timing: got rsp_cycle=%0d bad=%0d rready=%b expected %0d 0 0",
        o.c_rsp, o.bad_rdy, rready, TO);
    end
`else
    n_chk++;
    if (o.ok || o.c_rsp != -1 || rready !== 1'b1 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL no_tmo_wait: got ok=%0d rsp_cycle=%0d rready=%b tmo=%b expected 0 -1 1 0",
        o.ok, o.c_rsp, rready, rsp_timeout);
    end
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_slow_aw();
    test_errors();
    test_rsp_hold();
    test_stray();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
